// File: rtl/cb_sram_slave.sv
// cb_sram_slave: core-bus responder that terminates the data-side bus in a
// word-organised, byte-strobed local SRAM (tightly coupled data memory).
//
// The two bus bundles are carried as flat packed vectors, MSB first:
//   data_cb_mosi_i [108:0] = { rd_addr[31:0], rd_size[1:0], rd_addr_valid, rd_ready,
//                              wr_addr[31:0], wr_size[1:0], wr_addr_valid,
//                              wr_data[31:0], wr_strobe[3:0], wr_data_valid,
//                              wr_resp_ready }
//   data_cb_miso_o [40:0]  = { rd_addr_ready, rd_data[31:0], rd_valid, rd_resp[1:0],
//                              wr_addr_ready, wr_data_ready, wr_resp_valid,
//                              wr_resp_error[1:0] }
// Response codes: CB_OKAY = 2'b00, CB_SLVERR = 2'b10.
//
// Reads and writes are handled by two independent FSMs. Every transfer is one
// 32-bit word; size fields and address bits [1:0] are ignored.

module cb_sram_slave #(
    parameter int unsigned MEM_KB    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter bit          WR_FIRST  = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [108:0] data_cb_mosi_i,
    output logic [40:0]  data_cb_miso_o
);

    localparam int unsigned DEPTH     = MEM_KB * 256;
    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [31:0] MEM_BYTES = 32'(MEM_KB * 1024);

    localparam logic [1:0] CB_OKAY   = 2'b00;
    localparam logic [1:0] CB_SLVERR = 2'b10;

    typedef enum logic {
        RdIdle,
        RdResp
    } rd_state_e;

    typedef enum logic [1:0] {
        WrIdle,
        WrData,
        WrResp
    } wr_state_e;

    // ------------------------------------------------------------------
    // Bus field unpacking
    // ------------------------------------------------------------------
    logic [31:0] w_rd_addr;
    logic [1:0]  w_rd_size;
    logic        w_rd_addr_valid;
    logic        w_rd_ready;
    logic [31:0] w_wr_addr;
    logic [1:0]  w_wr_size;
    logic        w_wr_addr_valid;
    logic [31:0] w_wr_data;
    logic [3:0]  w_wr_strobe;
    logic        w_wr_data_valid;
    logic        w_wr_resp_ready;

    assign {w_rd_addr, w_rd_size, w_rd_addr_valid, w_rd_ready,
            w_wr_addr, w_wr_size, w_wr_addr_valid,
            w_wr_data, w_wr_strobe, w_wr_data_valid,
            w_wr_resp_ready} = data_cb_mosi_i;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    rd_state_e       r_rd_state;
    logic [31:0]     r_rd_data;
    logic [1:0]      r_rd_resp;

    wr_state_e       r_wr_state;
    logic [AW-1:0]   r_wr_idx;
    logic            r_wr_in_range;
    logic [1:0]      r_wr_resp;

    logic [31:0]     r_mem [0:DEPTH-1];

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0]   w_rd_off;
    logic [31:0]   w_wr_off;
    logic          w_rd_in_range;
    logic          w_wr_in_range;
    logic [AW-1:0] w_rd_idx;
    logic [AW-1:0] w_wr_idx;

    // Unsigned wrap of the subtraction makes addresses below the base land
    // far above MEM_BYTES, so one compare covers both window edges.
    assign w_rd_off      = w_rd_addr - BASE_ADDR;
    assign w_wr_off      = w_wr_addr - BASE_ADDR;
    assign w_rd_in_range = (w_rd_off < MEM_BYTES);
    assign w_wr_in_range = (w_wr_off < MEM_BYTES);
    assign w_rd_idx      = w_rd_off[AW+1:2];
    assign w_wr_idx      = w_wr_off[AW+1:2];

    // Size fields and byte-offset bits are intentionally ignored.
    logic w_unused_bits;
    assign w_unused_bits = ^{w_rd_size, w_wr_size, w_rd_off[1:0], w_wr_off[1:0]};

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    logic w_rd_addr_ready;
    logic w_wr_addr_ready;
    logic w_wr_data_ready;
    logic w_rd_accept;
    logic w_wr_addr_accept;
    logic w_wr_commit;

    assign w_rd_addr_ready = !rst && ((r_rd_state == RdIdle) ||
                                      ((r_rd_state == RdResp) && w_rd_ready));
    assign w_wr_addr_ready = !rst && ((r_wr_state == WrIdle) ||
                                      ((r_wr_state == WrResp) && w_wr_resp_ready));
    assign w_wr_data_ready = !rst && (r_wr_state == WrData);

    assign w_rd_accept      = w_rd_addr_valid && w_rd_addr_ready;
    assign w_wr_addr_accept = w_wr_addr_valid && w_wr_addr_ready;
    assign w_wr_commit      = w_wr_data_valid && w_wr_data_ready;

    // ------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------
    logic [31:0] w_rd_old;
    logic [31:0] w_rd_word;
    logic        w_collide;

    assign w_rd_old  = r_mem[w_rd_idx];
    assign w_collide = w_wr_commit && r_wr_in_range && w_rd_in_range &&
                       (r_wr_idx == w_rd_idx);

    // Forward strobed write bytes into a same-cycle read of the same word.
    always_comb begin
        w_rd_word = w_rd_old;
        if (WR_FIRST && w_collide) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wr_strobe[i]) begin
                    w_rd_word[8*i +: 8] = w_wr_data[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory array: byte-lane writes on commit, never reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_commit && r_wr_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wr_strobe[i]) begin
                    r_mem[r_wr_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read FSM: latch word and response on accept, hold until rd_ready
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= RdIdle;
            r_rd_data  <= '0;
            r_rd_resp  <= CB_OKAY;
        end else begin
            if (w_rd_accept) begin
                r_rd_state <= RdResp;
                r_rd_data  <= w_rd_in_range ? w_rd_word : 32'h0;
                r_rd_resp  <= w_rd_in_range ? CB_OKAY : CB_SLVERR;
            end else if ((r_rd_state == RdResp) && w_rd_ready) begin
                r_rd_state <= RdIdle;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write FSM: address, then data (commit), then response
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state    <= WrIdle;
            r_wr_idx      <= '0;
            r_wr_in_range <= 1'b0;
            r_wr_resp     <= CB_OKAY;
        end else begin
            unique case (r_wr_state)
                WrIdle: begin
                    if (w_wr_addr_accept) begin
                        r_wr_idx      <= w_wr_idx;
                        r_wr_in_range <= w_wr_in_range;
                        r_wr_state    <= WrData;
                    end
                end
                WrData: begin
                    if (w_wr_commit) begin
                        r_wr_resp  <= r_wr_in_range ? CB_OKAY : CB_SLVERR;
                        r_wr_state <= WrResp;
                    end
                end
                WrResp: begin
                    if (w_wr_resp_ready) begin
                        if (w_wr_addr_accept) begin
                            r_wr_idx      <= w_wr_idx;
                            r_wr_in_range <= w_wr_in_range;
                            r_wr_state    <= WrData;
                        end else begin
                            r_wr_state <= WrIdle;
                        end
                    end
                end
                default: r_wr_state <= WrIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output packing; everything forced low while reset is asserted
    // ------------------------------------------------------------------
    always_comb begin
        data_cb_miso_o = '0;
        if (!rst) begin
            data_cb_miso_o = {w_rd_addr_ready, r_rd_data, (r_rd_state == RdResp), r_rd_resp,
                              w_wr_addr_ready, w_wr_data_ready, (r_wr_state == WrResp),
                              r_wr_resp};
        end
    end

endmodule

// File: tb/tb_cb_sram_slave.sv
// tb_cb_sram_slave: directed and randomized checks of cb_sram_slave against a
// word-array reference model of the SRAM window.

module tb_cb_sram_slave;

    localparam logic [31:0] BASE      = 32'h0000_0000;
    localparam logic [31:0] MEM_BYTES = 32'd8192;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [108:0] mosi;
    logic [40:0]  miso;

    // initiator-side fields
    logic [31:0] rd_addr = '0;
    logic [1:0]  rd_size = '0;
    logic        rd_addr_valid = 1'b0;
    logic        rd_ready = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [1:0]  wr_size = '0;
    logic        wr_addr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_strobe = '0;
    logic        wr_data_valid = 1'b0;
    logic        wr_resp_ready = 1'b0;

    // responder-side fields
    logic        m_rd_addr_ready;
    logic [31:0] m_rd_data;
    logic        m_rd_valid;
    logic [1:0]  m_rd_resp;
    logic        m_wr_addr_ready;
    logic        m_wr_data_ready;
    logic        m_wr_resp_valid;
    logic [1:0]  m_wr_resp_error;

    assign mosi = {rd_addr, rd_size, rd_addr_valid, rd_ready,
                   wr_addr, wr_size, wr_addr_valid,
                   wr_data, wr_strobe, wr_data_valid, wr_resp_ready};
    assign {m_rd_addr_ready, m_rd_data, m_rd_valid, m_rd_resp,
            m_wr_addr_ready, m_wr_data_ready, m_wr_resp_valid, m_wr_resp_error} = miso;

    cb_sram_slave #(
        .MEM_KB   (8),
        .BASE_ADDR(BASE),
        .WR_FIRST (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_cb_mosi_i(mosi),
        .data_cb_miso_o(miso)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference memory: one 32-bit word per entry
    logic [31:0] model [0:2047];

    function automatic logic in_rng(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < MEM_BYTES;
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off >> 2);
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        if (in_rng(a)) return model[widx(a)];
        return 32'h0;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return in_rng(a) ? 2'b00 : 2'b10;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (in_rng(a)) begin
            for (int i = 0; i < 4; i++) begin
                if (s[i]) model[widx(a)][8*i +: 8] = d[8*i +: 8];
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 8) return 32'(($urandom_range(0, 63) << 2) | $urandom_range(0, 3));
        if (r == 8) return 32'h2000 + 32'($urandom_range(0, 63) << 2);
        return 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
    endfunction

    // One complete write with optional early data and stall cycles.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int early, input int dly_data, input int dly_resp);
        logic [1:0] er;
        er = exp_resp(a);
        wr_addr = a;
        wr_size = 2'($urandom_range(0, 3));
        wr_addr_valid = 1'b1;
        wr_data = d;
        wr_strobe = s;
        wr_data_valid = (early != 0);
        #1;
        chk("wr_addr_ready", 64'(m_wr_addr_ready), 64'd1);
        if (early != 0) chk("wr_data_early", 64'(m_wr_data_ready), 64'd0);
        tick();
        wr_addr_valid = 1'b0;
        if (early == 0) begin
            repeat (dly_data) begin
                chk("wr_resp_idle", 64'(m_wr_resp_valid), 64'd0);
                tick();
            end
            wr_data_valid = 1'b1;
        end
        #1;
        chk("wr_data_ready", 64'(m_wr_data_ready), 64'd1);
        tick();
        model_write(a, d, s);
        wr_data_valid = 1'b0;
        wr_resp_ready = 1'b0;
        repeat (dly_resp) begin
            chk("wr_resp_valid_hold", 64'(m_wr_resp_valid), 64'd1);
            chk("wr_resp_err_hold", 64'(m_wr_resp_error), 64'(er));
            chk("wr_addr_ready_bp", 64'(m_wr_addr_ready), 64'd0);
            tick();
        end
        wr_resp_ready = 1'b1;
        #1;
        chk("wr_resp_valid", 64'(m_wr_resp_valid), 64'd1);
        chk("wr_resp_err", 64'(m_wr_resp_error), 64'(er));
        chk("wr_addr_ready_hs", 64'(m_wr_addr_ready), 64'd1);
        tick();
        wr_resp_ready = 1'b0;
        #1;
        chk("wr_resp_drop", 64'(m_wr_resp_valid), 64'd0);
    endtask

    // One complete read with an explicit expectation and rd_ready stall cycles.
    task automatic do_read_x(input logic [31:0] a, input int dly,
                             input logic [31:0] ed, input logic [1:0] er);
        rd_addr = a;
        rd_size = 2'($urandom_range(0, 3));
        rd_addr_valid = 1'b1;
        rd_ready = (dly == 0);
        #1;
        chk("rd_addr_ready", 64'(m_rd_addr_ready), 64'd1);
        tick();
        rd_addr_valid = 1'b0;
        repeat (dly) begin
            chk("rd_valid_hold", 64'(m_rd_valid), 64'd1);
            chk("rd_data_hold", 64'(m_rd_data), 64'(ed));
            chk("rd_resp_hold", 64'(m_rd_resp), 64'(er));
            chk("rd_addr_ready_bp", 64'(m_rd_addr_ready), 64'd0);
            tick();
        end
        rd_ready = 1'b1;
        #1;
        chk("rd_valid", 64'(m_rd_valid), 64'd1);
        chk("rd_data", 64'(m_rd_data), 64'(ed));
        chk("rd_resp", 64'(m_rd_resp), 64'(er));
        tick();
        rd_ready = 1'b0;
        #1;
        chk("rd_valid_drop", 64'(m_rd_valid), 64'd0);
    endtask

    task automatic do_read(input logic [31:0] a, input int dly);
        do_read_x(a, dly, exp_rdata(a), exp_resp(a));
    endtask

    // Write commit and read accept in the same cycle; the read sees the write.
    task automatic do_collide(input logic [31:0] wa, input logic [31:0] ra,
                              input logic [31:0] d, input logic [3:0] s);
        logic [31:0] ed;
        wr_addr = wa;
        wr_addr_valid = 1'b1;
        tick();
        wr_addr_valid = 1'b0;
        wr_data = d;
        wr_strobe = s;
        wr_data_valid = 1'b1;
        rd_addr = ra;
        rd_addr_valid = 1'b1;
        rd_ready = 1'b0;
        #1;
        chk("col_rd_addr_ready", 64'(m_rd_addr_ready), 64'd1);
        chk("col_wr_data_ready", 64'(m_wr_data_ready), 64'd1);
        tick();
        model_write(wa, d, s);
        ed = exp_rdata(ra);
        wr_data_valid = 1'b0;
        rd_addr_valid = 1'b0;
        chk("col_rd_valid", 64'(m_rd_valid), 64'd1);
        chk("col_rd_data", 64'(m_rd_data), 64'(ed));
        chk("col_rd_resp", 64'(m_rd_resp), 64'(exp_resp(ra)));
        chk("col_wr_resp_valid", 64'(m_wr_resp_valid), 64'd1);
        chk("col_wr_resp_err", 64'(m_wr_resp_error), 64'(exp_resp(wa)));
        rd_ready = 1'b1;
        wr_resp_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        wr_resp_ready = 1'b0;
        #1;
        chk("col_rd_drop", 64'(m_rd_valid), 64'd0);
        chk("col_wr_drop", 64'(m_wr_resp_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] ra;

        // reset with valids asserted: nothing may be accepted or driven
        rst = 1'b1;
        rd_addr_valid = 1'b1;
        wr_addr_valid = 1'b1;
        wr_data_valid = 1'b1;
        repeat (3) begin
            tick();
            chk("rst_miso", 64'(miso), 64'd0);
        end
        rd_addr_valid = 1'b0;
        wr_addr_valid = 1'b0;
        wr_data_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("idle_rd_addr_ready", 64'(m_rd_addr_ready), 64'd1);
        chk("idle_wr_addr_ready", 64'(m_wr_addr_ready), 64'd1);
        chk("idle_rd_valid", 64'(m_rd_valid), 64'd0);
        chk("idle_wr_resp_valid", 64'(m_wr_resp_valid), 64'd0);
        chk("idle_wr_data_ready", 64'(m_wr_data_ready), 64'd0);
        tick();

        // known contents for the low 64 words
        for (int w = 0; w < 64; w++) begin
            do_write(32'(w << 2), $urandom, 4'hF, 0, 0, 0);
        end

        // full-word write and read back
        do_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        do_read_x(32'h10, 0, 32'hDEAD_BEEF, 2'b00);

        // partial strobe merge
        do_write(32'h20, 32'h1122_3344, 4'hF, 0, 0, 0);
        do_write(32'h20, 32'hAABB_CCDD, 4'b0110, 0, 0, 0);
        do_read_x(32'h20, 0, 32'h11BB_CC44, 2'b00);

        // back-to-back reads under back-pressure
        rd_addr = 32'h0;
        rd_addr_valid = 1'b1;
        rd_ready = 1'b0;
        tick();
        rd_addr = 32'h4;
        repeat (3) begin
            chk("bp_rd_valid", 64'(m_rd_valid), 64'd1);
            chk("bp_rd_data0", 64'(m_rd_data), 64'(model[0]));
            chk("bp_rd_addr_ready", 64'(m_rd_addr_ready), 64'd0);
            tick();
        end
        rd_ready = 1'b1;
        #1;
        chk("bp_rd_addr_ready_hs", 64'(m_rd_addr_ready), 64'd1);
        chk("bp_first", 64'(m_rd_data), 64'(model[0]));
        tick();
        rd_addr_valid = 1'b0;
        chk("bp_second_valid", 64'(m_rd_valid), 64'd1);
        chk("bp_second", 64'(m_rd_data), 64'(model[1]));
        tick();
        rd_ready = 1'b0;
        chk("bp_done", 64'(m_rd_valid), 64'd0);

        // out-of-range accesses; 0x2000 would alias word 0 if not rejected
        do_read_x(32'h2000, 0, 32'h0, 2'b10);
        do_write(32'h2000, 32'h0BAD_0BAD, 4'hF, 0, 0, 0);
        do_read(32'h0, 0);
        do_write(32'h1FFC, 32'h7654_3210, 4'hF, 0, 1, 1);
        do_read_x(32'h1FFC, 0, 32'h7654_3210, 2'b00);

        // zero strobe: OKAY, no change
        do_write(32'h8, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0);
        do_read(32'h8, 0);

        // early write data must wait for the address
        do_write(32'h18, 32'h0123_4567, 4'hF, 1, 0, 0);
        do_read(32'h18, 1);

        // same-word collisions
        do_collide(32'h40, 32'h40, 32'hCAFE_F00D, 4'hF);
        do_collide(32'h40, 32'h42, 32'h1234_5678, 4'b0101);
        do_read_x(32'h40, 0, 32'hCA34_F078, 2'b00);

        // reset during a pending read response
        rd_addr = 32'h10;
        rd_addr_valid = 1'b1;
        rd_ready = 1'b0;
        tick();
        rd_addr_valid = 1'b0;
        chk("rr_rd_valid", 64'(m_rd_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("rr_miso", 64'(miso), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rr_rd_valid_after", 64'(m_rd_valid), 64'd0);
        chk("rr_rd_addr_ready", 64'(m_rd_addr_ready), 64'd1);
        tick();

        // reset during a pending write response; the committed data stays
        wr_addr = 32'h30;
        wr_addr_valid = 1'b1;
        tick();
        wr_addr_valid = 1'b0;
        wr_data = 32'h5A5A_1234;
        wr_strobe = 4'hF;
        wr_data_valid = 1'b1;
        tick();
        model_write(32'h30, 32'h5A5A_1234, 4'hF);
        wr_data_valid = 1'b0;
        chk("wr_rst_resp_valid", 64'(m_wr_resp_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("wr_rst_miso", 64'(miso), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("wr_rst_resp_drop", 64'(m_wr_resp_valid), 64'd0);
        chk("wr_rst_addr_ready", 64'(m_wr_addr_ready), 64'd1);
        tick();
        do_read_x(32'h30, 0, 32'h5A5A_1234, 2'b00);

        // randomized traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            a = rnd_addr();
            case ($urandom_range(0, 2))
                0: do_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                            int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
                1: do_read(a, int'($urandom_range(0, 3)));
                default: begin
                    ra = ($urandom_range(0, 1) == 1) ? {a[31:2], 2'($urandom_range(0, 3))}
                                                     : rnd_addr();
                    do_collide(a, ra, $urandom, 4'($urandom_range(0, 15)));
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cb_sram_slave.md
Name: cb_sram_slave

Overview:
Core-bus responder that terminates the data-side core bus in a word-organised, byte-strobed local SRAM (tightly coupled data memory). It accepts independent read and write address/data phases from a core-bus initiator such as the core's load/store unit. It returns read data and write responses with fixed minimum latency and full back-pressure support. Accesses outside the mapped window get an error response.

Parameters:
MEM_KB, 8, memory size in KiB; depth = MEM_KB*256 words of 32 bits
BASE_ADDR, 32'h0000_0000, byte base address of the window; must be aligned to the memory size
WR_FIRST, 1, 1 = a read accepted in the same cycle as a write commit to the same word returns the merged new data; 0 = it returns the old data

Ports:
clk  input  1  core clock
rst  input  1  reset, synchronous, active-high
data_cb_mosi_i  input  s_cb_mosi_t  initiator-to-responder fields: rd_addr, rd_size, rd_addr_valid, rd_ready, wr_addr, wr_size, wr_addr_valid, wr_data, wr_strobe, wr_data_valid, wr_resp_ready
data_cb_miso_o  output  s_cb_miso_t  responder-to-initiator fields: rd_addr_ready, rd_data, rd_valid, rd_resp, wr_addr_ready, wr_data_ready, wr_resp_valid, wr_resp_error

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: while rst is high, all miso outputs are 0, including every ready. The FSMs go to RD_IDLE and WR_IDLE. Memory contents are not reset.
- Addressing:
  - Word index = (addr - BASE_ADDR) >> 2. Address bits [1:0] are ignored.
  - In-range means BASE_ADDR <= addr < BASE_ADDR + MEM_KB*1024.
  - rd_size and wr_size are ignored; every transfer is one 32-bit word.
- Read FSM (RD_IDLE, RD_RESP):
  - rd_addr_ready = (RD_IDLE) or (RD_RESP and rd_ready).
  - Accept occurs when rd_addr_valid and rd_addr_ready are both high. On accept, latch the data (word, or 0 if out of range) and the response (CB_OKAY or CB_SLVERR). Go to RD_RESP.
  - In RD_RESP, rd_valid = 1. rd_data and rd_resp stay stable until rd_ready is high.
  - On the rd_ready handshake: a new accept in the same cycle stays in RD_RESP with the new data on the next cycle; otherwise return to RD_IDLE.
  - Latency: rd_valid rises 1 cycle after accept. Throughput is 1 read per cycle while rd_ready stays high.
- Write FSM (WR_IDLE, WR_DATA, WR_RESP):
  - wr_addr_ready = (WR_IDLE) or (WR_RESP and wr_resp_ready). On accept, latch the address and go to WR_DATA.
  - In WR_DATA, wr_data_ready = 1. Data is never accepted before its address, even if wr_data_valid arrives early.
  - On the wr_data_valid handshake (commit): for each byte i with wr_strobe[i]=1, write wr_data[8i+:8] to the addressed word. Unstrobed bytes are unchanged. An out-of-range write has no memory effect and latches CB_SLVERR. Go to WR_RESP.
  - In WR_RESP, wr_resp_valid = 1 and wr_resp_error is held until wr_resp_ready.
  - On the response handshake: a new address accept in the same cycle goes to WR_DATA; otherwise go to WR_IDLE.
  - Latency: the response is valid 1 cycle after commit.
- Simultaneous events:
  - Read accept and write commit may occur in the same cycle; they are independent.
  - Same-word collision with WR_FIRST=1: rd_data = strobe-merged new word. With WR_FIRST=0: the old word.
- Strobe of 4'b0000: no memory change; the response is still CB_OKAY.
- Reset mid-transaction: any pending read or write response is dropped and the FSMs return to idle. A committed write remains in memory.

Test Plan:
1. Reset, then idle: rd_addr_ready=1 and wr_addr_ready=1 the cycle after rst falls; rd_valid=0 and wr_resp_valid=0.
2. Full-word write, then read back:
   - Write addr 0x10, data 0xDEADBEEF, strb 4'hF -> wr_resp_valid 1 cycle after commit with CB_OKAY.
   - Read 0x10 -> rd_data=0xDEADBEEF 1 cycle after accept, rd_resp=CB_OKAY.
3. Partial-strobe write: word 0x20 holds 0x11223344; write data 0xAABBCCDD with strb 4'b0110 -> a read returns 0x11BBCC44.
4. Read back-pressure:
   - Issue reads to 0x0 and 0x4 back-to-back while rd_ready=0 for 3 cycles -> the first read's data is held stable and rd_addr_ready=0.
   - After rd_ready rises, the two data words appear on consecutive cycles.
5. Out-of-range access (MEM_KB=8): read 0x2000 -> rd_resp=CB_SLVERR, rd_data=0. Write 0x2000 -> wr_resp_error=CB_SLVERR and no memory change.
6. Collision, WR_FIRST=1: commit a write of 0xCAFEF00D (strb F) to 0x40 in the same cycle a read of 0x40 is accepted -> rd_data=0xCAFEF00D.
